// File: rtl/user_reset_gen.sv
// Merges software, watchdog and filtered PLL lock-loss reset causes into one
// minimum-width active-low reset pulse followed by a hold-off window.
module user_reset_gen #(
  parameter int unsigned PULSE_CYCLES   = 16,
  parameter int unsigned HOLDOFF_CYCLES = 64,
  parameter int unsigned WDT_TIMEOUT    = 1000000,
  parameter int unsigned LOCK_FILTER    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_reset_req,
  input  logic       wdt_enable,
  input  logic       wdt_kick,
  input  logic       pll_lock,
  input  logic       cause_clr,
  output logic       user_reset,
  output logic       busy,
  output logic [2:0] cause,
  output logic [7:0] reset_count
);

  localparam int unsigned PHASE_MAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int unsigned PW = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
  localparam int unsigned WW = $clog2(WDT_TIMEOUT);
  localparam int unsigned FW = $clog2(LOCK_FILTER + 1);

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    HOLDOFF
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] ph_cnt, ph_cnt_n;
  logic          start_pulse;

  logic          lock_meta, lock_sync, lock_seen;
  logic [FW-1:0] flt_cnt;
  logic [WW-1:0] wdt_cnt;

  logic          lock_low;
  logic          sw_trig, wdt_trig, lock_trig, any_trig;

  assign lock_low  = lock_seen & ~lock_sync;
  // Filter counter saturates at LOCK_FILTER, so the compare fires once per low run.
  assign lock_trig = lock_low && (flt_cnt == FW'(LOCK_FILTER - 1));
  assign wdt_trig  = wdt_enable && !busy && !wdt_kick && (wdt_cnt == WW'(WDT_TIMEOUT - 1));
  assign sw_trig   = sw_reset_req;
  assign any_trig  = sw_trig | wdt_trig | lock_trig;

  always_comb begin
    state_n     = state;
    ph_cnt_n    = ph_cnt;
    start_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (any_trig) begin
          state_n     = ASSERT;
          ph_cnt_n    = '0;
          start_pulse = 1'b1;
        end
      end
      ASSERT: begin
        if (ph_cnt == PW'(PULSE_CYCLES - 1)) begin
          if (!lock_low) begin
            state_n  = HOLDOFF;
            ph_cnt_n = '0;
          end
        end else begin
          ph_cnt_n = ph_cnt + PW'(1);
        end
      end
      HOLDOFF: begin
        if (ph_cnt == PW'(HOLDOFF_CYCLES - 1)) begin
          ph_cnt_n = '0;
          if (any_trig) begin
            state_n     = ASSERT;
            start_pulse = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          ph_cnt_n = ph_cnt + PW'(1);
        end
      end
      default: begin
        state_n  = IDLE;
        ph_cnt_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ph_cnt      <= '0;
      user_reset  <= 1'b1;
      busy        <= 1'b0;
      cause       <= '0;
      reset_count <= '0;
      lock_meta   <= 1'b0;
      lock_sync   <= 1'b0;
      lock_seen   <= 1'b0;
      flt_cnt     <= '0;
      wdt_cnt     <= '0;
    end else begin
      state      <= state_n;
      ph_cnt     <= ph_cnt_n;
      user_reset <= (state_n != ASSERT);
      busy       <= (state_n != IDLE);

      lock_meta <= pll_lock;
      lock_sync <= lock_meta;
      if (lock_sync) lock_seen <= 1'b1;

      if (!lock_low) flt_cnt <= '0;
      else if (flt_cnt != FW'(LOCK_FILTER)) flt_cnt <= flt_cnt + FW'(1);

      if (!wdt_enable || busy || wdt_kick || wdt_trig) wdt_cnt <= '0;
      else wdt_cnt <= wdt_cnt + WW'(1);

      cause <= (cause & ~{3{cause_clr}}) | {lock_trig, wdt_trig, sw_trig};

      if (start_pulse && reset_count != 8'hFF) reset_count <= reset_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_user_reset_gen.sv
// Scoreboarded random/directed bench for user_reset_gen against a
// time-based reference model of pulse, hold-off, watchdog and lock filter.
module tb_user_reset_gen;

  localparam int unsigned P = 16;
  localparam int unsigned H = 64;
  localparam int unsigned W = 100;
  localparam int unsigned F = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sw_reset_req = 1'b0;
  logic       wdt_enable = 1'b0;
  logic       wdt_kick = 1'b0;
  logic       pll_lock = 1'b0;
  logic       cause_clr = 1'b0;
  logic       user_reset;
  logic       busy;
  logic [2:0] cause;
  logic [7:0] reset_count;

  always #5 clk = ~clk;

  user_reset_gen #(
    .PULSE_CYCLES  (P),
    .HOLDOFF_CYCLES(H),
    .WDT_TIMEOUT   (W),
    .LOCK_FILTER   (F)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sw_reset_req(sw_reset_req),
    .wdt_enable  (wdt_enable),
    .wdt_kick    (wdt_kick),
    .pll_lock    (pll_lock),
    .cause_clr   (cause_clr),
    .user_reset  (user_reset),
    .busy        (busy),
    .cause       (cause),
    .reset_count (reset_count)
  );

  typedef struct packed {
    logic       ur;
    logic       bz;
    logic [2:0] cs;
    logic [7:0] rc;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: pulses tracked by the edge index they started / released at.
  int   k = 0;
  bit   s1 = 0, s2 = 0, seen = 0;
  int   low_run = 0, wdt_age = 0;
  bit   active = 0;
  int   start_e = 0, rel_e = -1;
  bit [2:0] m_cause = '0;
  int   m_count = 0;

  task automatic cyc(input bit r, input bit s, input bit e, input bit kk, input bit l, input bit c);
    bit sync_low, t_sw, t_lk, t_wd, any, in_assert, hold_done, newp;
    exp_t x;
    @(negedge clk);
    #1;
    reset = r; sw_reset_req = s; wdt_enable = e; wdt_kick = kk; pll_lock = l; cause_clr = c;
    k++;
    if (r) begin
      s1 = 0; s2 = 0; seen = 0; low_run = 0; wdt_age = 0;
      active = 0; rel_e = -1; m_cause = '0; m_count = 0;
    end else begin
      sync_low  = seen && !s2;
      t_sw      = s;
      t_lk      = sync_low && (low_run + 1 == F);
      t_wd      = e && !active && !kk && (wdt_age + 1 == W);
      any       = t_sw | t_lk | t_wd;
      in_assert = active && rel_e < 0;
      hold_done = active && rel_e >= 0 && (k - rel_e == H);
      newp      = any && (!active || hold_done);
      low_run   = sync_low ? low_run + 1 : 0;
      wdt_age   = (!e || active || kk || t_wd) ? 0 : wdt_age + 1;
      if (in_assert && (k - start_e >= P) && !sync_low) rel_e = k;
      else if (hold_done) active = 0;
      if (newp) begin
        active = 1; start_e = k; rel_e = -1;
        if (m_count < 255) m_count++;
      end
      m_cause = (m_cause & {3{!c}}) | {t_lk, t_wd, t_sw};
      if (s2) seen = 1;
      s2 = s1;
      s1 = l;
    end
    x.ur = !(active && rel_e < 0);
    x.bz = active;
    x.cs = m_cause;
    x.rc = 8'(m_count);
    sb.push_back(x);
  endtask

  // Monitor: one expected entry per clock edge, compared half a cycle later.
  initial begin
    exp_t x;
    bit bad;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        vectors++;
        bad = 0;
        if (user_reset !== x.ur) begin
          $display("FAIL user_reset t=%0t got %b exp %b", $time, user_reset, x.ur); bad = 1;
        end
        if (busy !== x.bz) begin
          $display("FAIL busy t=%0t got %b exp %b", $time, busy, x.bz); bad = 1;
        end
        if (cause !== x.cs) begin
          $display("FAIL cause t=%0t got %b exp %b", $time, cause, x.cs); bad = 1;
        end
        if (reset_count !== x.rc) begin
          $display("FAIL reset_count t=%0t got %0d exp %0d", $time, reset_count, x.rc); bad = 1;
        end
        if (bad) miscompares++;
      end
    end
  end

  initial begin
    int lens[7] = '{7, 8, 5, 12, 1, 8, 7};
    bit lk;
    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    // No lock ever seen: lock low must not trigger.
    repeat (500) cyc(0, 0, 0, 0, 0, 0);
    repeat (20) cyc(0, 0, 0, 0, 1, 0);
    foreach (lens[i]) begin
      repeat (lens[i]) cyc(0, 0, 0, 0, 0, 0);
      repeat (120) cyc(0, 0, 0, 0, 1, 0);
    end
    // Long lock loss stretches the pulse.
    repeat (48) cyc(0, 0, 0, 0, 0, 0);
    repeat (150) cyc(0, 0, 0, 0, 1, 0);
    // Software request, then request+clear during hold-off.
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 1, 0, 0, 1, 0);
    repeat (40) cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 1, 1);
    repeat (60) cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 1);
    // Watchdog without kicks, then kicked every 50 cycles.
    repeat (300) cyc(0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 1000; i++) cyc(0, 0, 1, (i % 50) == 49, 1, 0);
    repeat (10) cyc(0, 0, 0, 0, 1, 0);
    // Random mix.
    lk = 1;
    for (int i = 0; i < 4000; i++) begin
      if (lk) lk = ($urandom_range(0, 79) != 0);
      else    lk = ($urandom_range(0, 5) == 0);
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 9) != 0,
          $urandom_range(0, 29) == 0, lk, $urandom_range(0, 39) == 0);
    end
    repeat (150) cyc(0, 0, 0, 0, 1, 0);
    // Reset in the middle of a pulse.
    cyc(0, 1, 0, 0, 1, 0);
    repeat (5) cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0);
    repeat (5) cyc(0, 0, 0, 0, 1, 0);
    // Back-to-back requests drive the counter into saturation.
    repeat (300 * 81) cyc(0, 1, 0, 0, 1, 0);
    repeat (10) cyc(0, 0, 0, 0, 1, 0);
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain left %0d exp 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
